// File: rtl/secure_credential_tx.sv
// Credential transmitter: buffers a multi-word secret, whitens it with a keyed
// 16-bit Galois LFSR keystream on a valid/ready link, then zeroizes the buffer.
module secure_credential_tx #(
  parameter int          DATA_W   = 8,
  parameter int          DEPTH    = 16,
  parameter logic [15:0] DEF_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [15:0]                key_in,
  input  logic                       start,
  input  logic                       abort,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       done,
  output logic                       aborted
);

  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] cred_buf [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, clr_ptr;
  logic [15:0]       lfsr, lfsr_step, seed;
  logic              abort_latched;
  logic              fill_nz, last_word, clr_last;
  logic              wr_fire, start_ok, abort_ok, tx_fire;

  assign fill_nz   = (fill != '0);
  assign last_word = (FILL_W'(rd_ptr) == (fill - FILL_W'(1)));
  assign clr_last  = (clr_ptr == PTR_W'(DEPTH - 1));
  assign seed      = (key_in == 16'h0000) ? DEF_SEED : key_in;
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // tx_data is forced to zero outside SEND so buffer contents cannot leak.
  always_comb begin
    state_next = state;
    wr_ready   = 1'b0;
    wr_fire    = 1'b0;
    start_ok   = 1'b0;
    abort_ok   = 1'b0;
    tx_fire    = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = (fill < FILL_W'(DEPTH)) && !start && !abort;
        wr_fire  = wr_valid && wr_ready;
        abort_ok = abort && fill_nz;
        start_ok = start && fill_nz && !abort;
        if (abort_ok)      state_next = CLEAR;
        else if (start_ok) state_next = SEND;
      end
      SEND: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = cred_buf[rd_ptr] ^ lfsr[DATA_W-1:0];
        abort_ok = abort;
        tx_fire  = tx_ready && !abort;
        if (abort_ok || (tx_fire && last_word)) state_next = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Abort wins over start and over a same-cycle handshake; the keystream is
  // wiped on every entry into CLEAR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill          <= '0;
      rd_ptr        <= '0;
      clr_ptr       <= '0;
      lfsr          <= '0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      abort_latched <= 1'b0;
      for (int i = 0; i < DEPTH; i++) cred_buf[i] <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (abort_ok) begin
            abort_latched <= 1'b1;
            lfsr          <= '0;
            clr_ptr       <= '0;
          end else if (start_ok) begin
            lfsr   <= seed;
            rd_ptr <= '0;
          end else if (wr_fire) begin
            cred_buf[fill[PTR_W-1:0]] <= wr_data;
            fill                      <= fill + FILL_W'(1);
          end
        end
        SEND: begin
          if (abort_ok) begin
            abort_latched <= 1'b1;
            lfsr          <= '0;
            clr_ptr       <= '0;
          end else if (tx_fire) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            lfsr    <= last_word ? 16'h0000 : lfsr_step;
            clr_ptr <= '0;
          end
        end
        CLEAR: begin
          cred_buf[clr_ptr] <= '0;
          if (clr_last) begin
            fill          <= '0;
            rd_ptr        <= '0;
            clr_ptr       <= '0;
            abort_latched <= 1'b0;
            done          <= !abort_latched;
            aborted       <= abort_latched;
          end else begin
            clr_ptr <= clr_ptr + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_credential_tx.sv
// Scoreboard bench for secure_credential_tx: expected whitened words are queued
// at start and popped whenever a tx handshake is observed.
module tb_secure_credential_tx;

  localparam int DEPTH = 16;

  logic        clk;
  logic        reset_n;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] key_in;
  logic        start;
  logic        abort;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [4:0]  fill;
  logic        done;
  logic        aborted;

  int         checks = 0;
  int         errors = 0;
  int         cycleCount = 0;
  int         startEdge = 0;
  logic [7:0] modelBuf[$];
  logic [7:0] sbQ[$];

  secure_credential_tx #(.DATA_W(8), .DEPTH(DEPTH), .DEF_SEED(16'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .key_in(key_in), .start(start), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .fill(fill), .done(done), .aborted(aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    lfsrNext = {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshakes happen at the next rising edge; abort in the same cycle cancels them.
  always @(negedge clk) begin
    if (reset_n) begin
      if (tx_valid && tx_ready && !abort) begin
        if (sbQ.size() == 0) checkOutput("sb_has_entry", 32'(sbQ.size()), 1);
        else checkOutput("tx_word", tx_data, sbQ.pop_front());
      end
      if (!tx_valid) checkOutput("leak", tx_data, 0);
    end
  end

  task automatic writeWord(input logic [7:0] w);
    wr_data  = w;
    wr_valid = 1'b1;
    @(negedge clk);
    checkOutput("wr_ready", wr_ready, (modelBuf.size() < DEPTH));
    if (modelBuf.size() < DEPTH) modelBuf.push_back(w);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] key);
    logic [15:0] s;
    s = (key == 16'h0000) ? 16'hACE1 : key;
    foreach (modelBuf[i]) begin
      sbQ.push_back(modelBuf[i] ^ s[7:0]);
      s = lfsrNext(s);
    end
    modelBuf.delete();
    key_in = key;
    start  = 1'b1;
    tick();
    start     = 1'b0;
    startEdge = cycleCount;
  endtask

  task automatic waitPulse(input bit wantAbort, input int latency, input string tag);
    int n;
    bit seen, other;
    n = 0; seen = 0; other = 0;
    while (n < 300 && !seen) begin
      tick();
      n++;
      if (wantAbort ? aborted : done) seen = 1;
      if (wantAbort ? done : aborted) other = 1;
    end
    checkOutput({tag, "_latency"}, 32'(cycleCount - startEdge), 32'(latency));
    checkOutput({tag, "_other_pulse"}, other, 0);
    checkOutput({tag, "_fill"}, fill, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_wr_ready"}, wr_ready, 1);
    checkOutput({tag, "_sb_left"}, 32'(sbQ.size()), 0);
    tick();
    checkOutput({tag, "_pulse_once"}, wantAbort ? aborted : done, 0);
  endtask

  initial begin
    reset_n = 1'b0; wr_data = '0; wr_valid = 1'b0; key_in = '0;
    start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_fill", fill, 0);
    checkOutput("rst_done", {done, aborted}, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("empty_start_busy", busy, 0);
    checkOutput("empty_start_tx_valid", tx_valid, 0);

    writeWord(8'h55); writeWord(8'hAA); writeWord(8'h3C);
    checkOutput("basic_fill", fill, 3);
    tx_ready = 1'b1;
    applyStimulus(16'h00FF);
    waitPulse(0, 3 + DEPTH, "basic");

    writeWord(8'h55); writeWord(8'hAA); writeWord(8'h3C);
    applyStimulus(16'h00FF);
    tick();
    tx_ready = 1'b0;
    #1;
    begin
      logic [7:0] held;
      held = sbQ[0];
      for (int i = 0; i < 3; i++) begin
        checkOutput("bp_hold_data", tx_data, held);
        checkOutput("bp_hold_valid", tx_valid, 1);
        tick();
      end
    end
    tx_ready = 1'b1;
    waitPulse(0, 3 + 3 + DEPTH, "bp");

    writeWord(8'h00);
    wr_data = 8'h99; wr_valid = 1'b1; start = 1'b1;
    #1;
    checkOutput("start_blocks_write", wr_ready, 0);
    applyStimulus(16'h0000);
    wr_valid = 1'b0;
    checkOutput("zero_key_fill", fill, 1);
    waitPulse(0, 1 + DEPTH, "zero_key");

    for (int i = 0; i < DEPTH + 2; i++) writeWord(8'(i * 37 + 5));
    checkOutput("full_fill", fill, DEPTH);
    checkOutput("full_wr_ready", wr_ready, 0);
    applyStimulus(16'h1234);
    waitPulse(0, DEPTH + DEPTH, "full");

    writeWord(8'h11); writeWord(8'h22); writeWord(8'h33);
    applyStimulus(16'h5A5A);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    startEdge = cycleCount;
    checkOutput("abort_tx_valid", tx_valid, 0);
    checkOutput("abort_tx_data", tx_data, 0);
    checkOutput("abort_busy", busy, 1);
    checkOutput("abort_unsent", 32'(sbQ.size()), 2);
    sbQ.delete();
    waitPulse(1, DEPTH, "abort");
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("post_abort_start_busy", busy, 0);

    writeWord(8'h44);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    startEdge = cycleCount;
    waitPulse(1, DEPTH, "idle_abort");

    writeWord(8'h01); writeWord(8'h02); writeWord(8'h03);
    tx_ready = 1'b0;
    applyStimulus(16'h00FF);
    checkOutput("pre_rst_valid", tx_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx_valid", tx_valid, 0);
    checkOutput("mid_rst_tx_data", tx_data, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_fill", fill, 0);
    checkOutput("mid_rst_pulses", {done, aborted}, 0);
    sbQ.delete();
    tick();
    reset_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    checkOutput("post_rst_wr_ready", wr_ready, 1);

    writeWord(8'hC3);
    applyStimulus(16'hBEEF);
    waitPulse(0, 1 + DEPTH, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/secure_credential_tx.md
# secure_credential_tx

Parametrised credential transmitter that buffers a multi-word secret, whitens it with a keyed 16-bit Galois LFSR keystream and sends it over a valid/ready link. Cleartext never appears on the transmit port. The buffer is zeroized after every transmission or abort. It sits between the credential entry logic and the outbound serial/bus bridge.

## Interface
Parameters:
- DATA_W, 8: word width; legal range 1..16.
- DEPTH, 16: maximum credential length in words; must be ≥ 2.
- DEF_SEED, 16'hACE1: LFSR seed substituted when key_in == 0.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_data  in  DATA_W  credential word to buffer.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  buffer accepts a word.
- key_in  in  16  whitening key; sampled only when start is accepted.
- start  in  1  begin transmission of the buffered words.
- abort  in  1  discard the credential immediately.
- tx_data  out  DATA_W  whitened word.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts tx_data.
- busy  out  1  state ≠ IDLE.
- fill  out  $clog2(DEPTH+1)  number of buffered words.
- done  out  1  one-cycle pulse when a transmission completes.
- aborted  out  1  one-cycle pulse when an abort completes.

## Operation
- States: IDLE, SEND, CLEAR.
- Reset:
  - state = IDLE.
  - fill, rd_ptr, clr_ptr, lfsr, done, aborted, tx_valid = 0.
  - tx_data = 0 and all buffer entries = 0.
- IDLE:
  - wr_ready = (fill < DEPTH) && !start && !abort.
  - A word is accepted when wr_valid && wr_ready. It is stored at buf[fill], then fill increments.
  - When full, wr_valid is ignored.
- start in IDLE with fill > 0:
  - lfsr ← (key_in == 0) ? DEF_SEED : key_in.
  - rd_ptr ← 0; go to SEND.
  - start with fill == 0 is ignored.
  - start in SEND or CLEAR is ignored.
- SEND:
  - tx_valid = 1.
  - tx_data = buf[rd_ptr] ^ lfsr[DATA_W-1:0].
  - On tx_valid && tx_ready: rd_ptr increments and the LFSR steps once: lfsr ← (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0).
  - While tx_ready is low, tx_data and the LFSR hold.
  - When the word at rd_ptr == fill−1 is accepted, go to CLEAR.
- abort:
  - In SEND, or in IDLE with fill > 0, go to CLEAR next cycle. The abort is latched for the aborted pulse.
  - In IDLE with fill == 0, abort is ignored.
  - In CLEAR, abort is ignored.
  - abort has priority over start and over a tx handshake in the same cycle; that word counts as not sent.
- CLEAR:
  - Writes 0 to buf[clr_ptr], one entry per cycle, clr_ptr = 0..DEPTH−1. All DEPTH entries are cleared regardless of fill.
  - lfsr ← 0 on entry.
  - After entry DEPTH−1: fill, rd_ptr, clr_ptr ← 0, then go to IDLE.
  - On that transition, either done or aborted pulses for exactly one cycle.
- Leak rule: whenever tx_valid = 0, tx_data = 0. Buffer contents never reach any output unwhitened except through the XOR with the keystream.

## Timing
- start accepted at edge N: tx_valid = 1 from cycle N+1.
- With tx_ready held high, one word is sent per cycle. L words occupy cycles N+1..N+L.
- Last handshake at edge M:
  - tx_valid = 0 from M+1.
  - CLEAR occupies cycles M+1..M+DEPTH.
  - IDLE from M+DEPTH+1, with done = 1 in that cycle only.
  - wr_ready returns in the same cycle.
- abort sampled at edge A: tx_valid = 0 from A+1. IDLE with aborted = 1 at A+DEPTH+1.
- reset_n low at any time forces the reset values asynchronously, including mid-SEND and mid-CLEAR.
- busy = 1 during SEND and CLEAR only.

## Test plan
- Whitened send, key_in = 16'h00FF, DATA_W = 8:
  - Stimulus: write 0x55, 0xAA, 0x3C; start; tx_ready = 1.
  - Response: tx_data 0xAA, 0xD5, 0x03 on three consecutive cycles. done pulses 16 cycles after the last word. fill = 0 afterwards.
- Zero key:
  - Stimulus: key_in = 0, single word 0x00.
  - Response: tx_data = 0xE1, from DEF_SEED.
- Backpressure:
  - Stimulus: same as the whitened send, but tx_ready low for 3 cycles mid-stream.
  - Response: tx_data holds the stalled word. Output sequence unchanged at 0xAA, 0xD5, 0x03.
- Full buffer:
  - Stimulus: write DEPTH+2 words.
  - Response: wr_ready drops after DEPTH words; fill = DEPTH; the extra words are dropped.
- Abort mid-SEND:
  - Stimulus: abort after the 1st word is sent.
  - Response: tx_valid = 0 and tx_data = 0 next cycle. aborted pulses, done stays 0. A later start is ignored because fill = 0.
- Edge cases:
  - start with empty buffer: no state change.
  - reset_n pulse mid-SEND: all outputs return to their reset values immediately.
  - start and wr_valid in the same cycle: the write is rejected.
